// File: rtl/ex_stage_unit.sv
// ex_stage_unit: execute stage sitting behind the ID/EX pipeline registers.
//   Performs the ALU op, selects the destination register, resolves
//   branches/jumps and runs a 32-iteration shift-add multiplier that stalls
//   upstream while busy. Results are registered into the EX/MEM boundary.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   valid_in          ID/EX holds a live instruction
//   RegDst, ALUOp, ALUSrc, Jump, J_Jump   decoded control from ID/EX
//   rs_data, rt_data, imm, rt_addr, rd_addr, pc_plus4, jtarget   ID/EX data
//   stall_o           combinational hold request to ID/EX and earlier stages
//   valid_o, alu_result_o, store_data_o, write_reg_o   EX/MEM entry
//   redirect_o, redirect_pc_o   one-cycle fetch redirect and its target
module ex_stage_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              RegDst,
  input  logic [3:0]        ALUOp,
  input  logic              ALUSrc,
  input  logic [1:0]        Jump,
  input  logic              J_Jump,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [25:0]       jtarget,
  output logic              stall_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] write_reg_o,
  output logic              redirect_o,
  output logic [DATA_W-1:0] redirect_pc_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOR = 4'h5, OP_SLT = 4'h6, OP_SLL = 4'h7,
    OP_SRL = 4'h8, OP_SRA = 4'h9, OP_LUI = 4'hA, OP_MUL = 4'hB
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10, BR_JR = 2'b11
  } br_e;

  state_e            state;
  logic [DATA_W-1:0] mul_a, mul_b, acc, mul_store;
  logic [REG_AW-1:0] mul_dest;
  logic [4:0]        count;

  logic              is_mul, accept, taken;
  logic [DATA_W-1:0] op_b, alu_res, target, branch_tgt, acc_next;
  logic [REG_AW-1:0] dest;
  logic [4:0]        shamt;

  assign is_mul = (alu_op_e'(ALUOp) == OP_MUL);
  // Squash: a pending redirect means the instruction in ID/EX is wrong-path.
  assign accept = (state == S_IDLE) && valid_in && !redirect_o;
  assign dest   = RegDst ? rd_addr : rt_addr;
  assign op_b   = ALUSrc ? imm : rt_data;
  assign shamt  = imm[10:6];

  // Result is written on the count==31 edge, so upstream may advance then.
  assign stall_o = (accept && is_mul) || (state == S_BUSY && count != 5'd31);

  // The final iteration's add is folded into the value written out.
  assign acc_next = mul_b[0] ? acc + mul_a : acc;

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(ALUOp))
      OP_ADD: alu_res = rs_data + op_b;
      OP_SUB: alu_res = rs_data - op_b;
      OP_AND: alu_res = rs_data & op_b;
      OP_OR:  alu_res = rs_data | op_b;
      OP_XOR: alu_res = rs_data ^ op_b;
      OP_NOR: alu_res = ~(rs_data | op_b);
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs_data) < $signed(op_b))};
      OP_SLL: alu_res = op_b << shamt;
      OP_SRL: alu_res = op_b >> shamt;
      OP_SRA: alu_res = $unsigned($signed(op_b) >>> shamt);
      OP_LUI: alu_res = op_b << 16;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    branch_tgt = pc_plus4 + (imm << 2);
    taken      = 1'b0;
    target     = '0;
    if (J_Jump) begin
      taken  = 1'b1;
      target = {pc_plus4[DATA_W-1 -: 4], jtarget, 2'b00};
    end else begin
      case (br_e'(Jump))
        BR_BEQ: begin taken = (rs_data == rt_data); target = branch_tgt; end
        BR_BNE: begin taken = (rs_data != rt_data); target = branch_tgt; end
        BR_JR:  begin taken = 1'b1;                 target = rs_data;    end
        default: begin taken = 1'b0;                target = '0;         end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      valid_o       <= 1'b0;
      alu_result_o  <= '0;
      store_data_o  <= '0;
      write_reg_o   <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      acc           <= '0;
      mul_store     <= '0;
      mul_dest      <= '0;
      count         <= '0;
    end else begin
      valid_o    <= 1'b0;
      redirect_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mul_a     <= rs_data;
              mul_b     <= op_b;
              mul_dest  <= dest;
              mul_store <= rt_data;
              acc       <= '0;
              count     <= '0;
              state     <= S_BUSY;
            end else begin
              valid_o      <= 1'b1;
              alu_result_o <= alu_res;
              store_data_o <= rt_data;
              write_reg_o  <= dest;
              if (taken) begin
                redirect_o    <= 1'b1;
                redirect_pc_o <= target;
              end
            end
          end
        end
        S_BUSY: begin
          acc   <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            alu_result_o <= acc_next;
            store_data_o <= mul_store;
            write_reg_o  <= mul_dest;
            valid_o      <= 1'b1;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
